// File: rtl/multiword_add_seq.sv
// multiword_add_seq: adds two WORDS x 16-bit operands with one shared 16-bit adder.
// Each pass adds one 16-bit slice, least-significant word first. The carry from
// each pass is registered and fed into the next pass. The adder sits outside this
// block and is driven through add_x/add_y/add_cin; its result comes back through
// add_sum/add_cout in the same cycle.

module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    input  logic                  cin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout,
    output logic [15:0]           add_x,
    output logic [15:0]           add_y,
    output logic                  add_cin,
    input  logic [15:0]           add_sum,
    input  logic                  add_cout
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int OFFW = $clog2(16 * WORDS);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state;
    logic [IDXW-1:0]       idx;
    logic                  carry;
    logic [16*WORDS-1:0]   a_q;
    logic [16*WORDS-1:0]   b_q;
    logic [OFFW-1:0]       off;

    // The current word index scaled to a bit offset; WORDS=1 drops the unused top bit.
    assign off = OFFW'({idx, 4'b0000});

    // Handshake flags come straight from the registered state, so they never glitch.
    assign ready = (state != ST_RUN);
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);

    // Present the current slice to the external adder only while running; idle otherwise.
    always_comb begin
        add_x   = 16'h0000;
        add_y   = 16'h0000;
        add_cin = 1'b0;
        if (state == ST_RUN) begin
            add_x   = a_q[off +: 16];
            add_y   = b_q[off +: 16];
            add_cin = carry;
        end
    end

    // Sequencer: capture operands on accept, store one result word per RUN cycle,
    // latch the final carry on the last word, and allow back-to-back starts from DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum[off +: 16] <= add_sum;
                    carry          <= add_cout;
                    if (idx == LAST_IDX) begin
                        cout  <= add_cout;
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Testbench for multiword_add_seq: one WORDS=4 instance and one WORDS=1 instance,
// each wired to a behavioural 16-bit adder. A timing/arithmetic model predicts the
// handshake outputs every cycle; directed operations pin results against hand values.

module tb_multiword_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  start_v;
    logic [1:0]  cin_v;
    logic [63:0] a4, b4;
    logic [15:0] a1, b1;

    logic        ready4, busy4, done4, cout4;
    logic [63:0] sum4;
    logic [15:0] ax4, ay4, as4;
    logic        ac4, aco4;

    logic        ready1, busy1, done1, cout1;
    logic [15:0] sum1;
    logic [15:0] ax1, ay1, as1;
    logic        ac1, aco1;

    int checks   = 0;
    int failures = 0;

    // Behavioural Adder16Bit for each instance.
    assign {aco4, as4} = {1'b0, ax4} + {1'b0, ay4} + {16'b0, ac4};
    assign {aco1, as1} = {1'b0, ax1} + {1'b0, ay1} + {16'b0, ac1};

    multiword_add_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a4), .b(b4), .cin(cin_v[0]),
        .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
        .add_x(ax4), .add_y(ay4), .add_cin(ac4), .add_sum(as4), .add_cout(aco4)
    );

    multiword_add_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a1), .b(b1), .cin(cin_v[1]),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .add_x(ax1), .add_y(ay1), .add_cin(ac1), .add_sum(as1), .add_cout(aco1)
    );

    task automatic checkOutput(input string name, input logic [64:0] actual, input logic [64:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int wof(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic dutReady(input int i);
        return (i == 0) ? ready4 : ready1;
    endfunction

    function automatic logic dutBusy(input int i);
        return (i == 0) ? busy4 : busy1;
    endfunction

    function automatic logic dutDone(input int i);
        return (i == 0) ? done4 : done1;
    endfunction

    function automatic logic [64:0] dutRes(input int i);
        return (i == 0) ? {cout4, sum4} : {cout1, 48'b0, sum1};
    endfunction

    // Model: an operation accepted at edge acc is busy through edge acc+W-1 and
    // reports its result (a+b+cin, carry in bit 64) at edge acc+W.
    int          edgecnt = 0;
    int          acc[2];
    bit          act[2];
    logic [64:0] pend[2];
    logic [64:0] last[2];

    function automatic bit mBusy(input int i);
        return act[i] && (edgecnt >= acc[i]) && (edgecnt < acc[i] + wof(i));
    endfunction

    function automatic bit mDone(input int i);
        return act[i] && (edgecnt == acc[i] + wof(i));
    endfunction

    function automatic logic [64:0] calc(input int i);
        logic [16:0] r;
        if (i == 0) return {1'b0, a4} + {1'b0, b4} + 65'(cin_v[0]);
        r = {1'b0, a1} + {1'b0, b1} + 17'(cin_v[1]);
        return {r[16], 48'b0, r[15:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                act[i]  <= 1'b0;
                last[i] <= '0;
            end
        end else begin
            edgecnt <= edgecnt + 1;
            for (int i = 0; i < 2; i++) begin
                if (act[i] && (edgecnt + 1 == acc[i] + wof(i)))
                    last[i] <= pend[i];
                if (start_v[i] && !mBusy(i)) begin
                    act[i]  <= 1'b1;
                    acc[i]  <= edgecnt + 1;
                    pend[i] <= calc(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("mon%0d_ready", i), 65'(dutReady(i)), 65'(!mBusy(i)));
            checkOutput($sformatf("mon%0d_busy", i),  65'(dutBusy(i)),  65'(mBusy(i)));
            checkOutput($sformatf("mon%0d_done", i),  65'(dutDone(i)),  65'(mDone(i)));
            if (!mBusy(i))
                checkOutput($sformatf("mon%0d_result", i), dutRes(i), last[i]);
        end
    end

    task automatic applyStimulus(input int i, input logic [63:0] a, input logic [63:0] b, input logic c);
        if (i == 0) begin
            a4 = a;
            b4 = b;
        end else begin
            a1 = a[15:0];
            b1 = b[15:0];
        end
        cin_v[i]   = c;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        if (i == 0) begin
            a4 = ~a;
            b4 = ~b;
        end else begin
            a1 = ~a[15:0];
            b1 = ~b[15:0];
        end
        cin_v[i] = ~c;
    endtask

    task automatic waitDone(input int i, output int n);
        n = 0;
        while (!dutDone(i) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput($sformatf("done_seen%0d", i), 65'(dutDone(i)), 65'd1);
    endtask

    task automatic runOp(input string name, input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic c, input logic [64:0] expRes);
        int n;
        applyStimulus(i, a, b, c);
        waitDone(i, n);
        checkOutput({name, "_latency"}, 65'(1 + n), 65'(wof(i) + 1));
        checkOutput({name, "_result"}, dutRes(i), expRes);
        checkOutput({name, "_model"}, pend[i], expRes);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int dcount;
        rst     = 1'b1;
        start_v = 2'b00;
        cin_v   = 2'b00;
        a4 = '0; b4 = '0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_ready", 65'(ready4), 65'd1);
        checkOutput("reset_busy",  65'(busy4),  65'd0);
        checkOutput("reset_done",  65'(done4),  65'd0);
        checkOutput("reset_res",   {cout4, sum4}, 65'd0);

        runOp("small",  0, 64'h0000_0000_0000_996C, 64'h0000_0000_0000_AAAA, 1'b0,
              {1'b0, 64'h0000_0000_0001_4416});
        runOp("ripple", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, {1'b1, 64'h0});
        runOp("cin",    0, 64'hDD0C, 64'hCF22, 1'b1, {1'b0, 64'h0000_0000_0001_AC2F});
        runOp("mixed",  0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
              {1'b0, 64'h2222_2222_2222_2212});
        runOp("allmax", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});

        // Reset in the middle of an operation: abort, clear outputs, no done afterwards.
        applyStimulus(0, 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("partial_busy", 65'(busy4), 65'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", 65'(ready4), 65'd1);
        checkOutput("midrst_busy",  65'(busy4),  65'd0);
        checkOutput("midrst_res",   {cout4, sum4}, 65'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done4) dcount++;
        end
        checkOutput("midrst_nodone", 65'(dcount), 65'd0);

        // start held high across RUN is not re-accepted; then a back-to-back start from DONE.
        a4 = 64'h0000_0000_8000_8000;
        b4 = 64'h0000_0000_8000_8000;
        cin_v[0]   = 1'b0;
        start_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        waitDone(0, n);
        checkOutput("held_latency", 65'(3 + n), 65'd5);
        checkOutput("held_result", {cout4, sum4}, {1'b0, 64'h0000_0001_0001_0000});
        applyStimulus(0, 64'h0000_FFFF_0000_0001, 64'h0000_0001_0000_FFFF, 1'b0);
        waitDone(0, n);
        checkOutput("b2b_spacing", 65'(1 + n), 65'd5);
        checkOutput("b2b_result", {cout4, sum4}, {1'b0, 64'h0001_0000_0001_0000});
        @(posedge clk);
        #1;

        // Single-word instance.
        runOp("w1_basic", 1, 64'hFF00, 64'h00FF, 1'b0, {1'b0, 48'b0, 16'hFFFF});
        runOp("w1_carry", 1, 64'hFFFF, 64'h0000, 1'b1, {1'b1, 48'b0, 16'h0000});

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
